// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// This block shares the single write port of the 32x32 register file between two writeback
// requesters:
//   - port A: ALU and link results.
//   - port M: memory loads, including LWL/LWR partial-word merges.
//
// How it works:
//   - A combinational grant picks one winner per cycle.
//   - On the clock edge the winner is captured into a one-entry commit slot.
//   - The slot drives the file's write port for exactly one cycle and drains every cycle, so the
//     arbiter never back-pressures on its own account. Only contention and hold stall a requester.
//   - For LWL/LWR merges the file needs the old register contents. Read port 2 is redirected to
//     the slot's destination for that cycle, and port2_stolen tells the core that ReadData2 is
//     not serving it.
//   - Writes to $0, and requests with mode 00, are accepted and occupy the slot. Their write
//     enable is forced to 00.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   a_* / m_*           requester valid/ready handshake, destination, data, write mode
//   m_lsb               load address[1:0] (port A always commits with 00)
//   hold                core stall; blocks acceptance, slot still drains
//   core_ReadReg2       core's read-port-2 select, passed through unless stolen
//   RegWrite            write-enable code to the file: 11 word, 01 LWL, 10 LWR, 00 none
//   WriteReg/WriteData  slot destination and data
//   data_address2LSB    slot byte offset for merges
//   ReadReg2            muxed read-port-2 select
//   port2_stolen        read port 2 is serving a merge this cycle
//   pend_valid/pend_reg slot occupancy and destination, for hazard detection
//   conflict_count      saturating count of contested, non-held cycles

module regfile_write_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_reg,
  input  logic [31:0]      a_data,
  input  logic [1:0]       a_mode,

  input  logic             m_valid,
  output logic             m_ready,
  input  logic [4:0]       m_reg,
  input  logic [31:0]      m_data,
  input  logic [1:0]       m_mode,
  input  logic [1:0]       m_lsb,

  input  logic             hold,
  input  logic [4:0]       core_ReadReg2,

  output logic [1:0]       RegWrite,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic [1:0]       data_address2LSB,
  output logic [4:0]       ReadReg2,
  output logic             port2_stolen,

  output logic             pend_valid,
  output logic [4:0]       pend_reg,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic [1:0] ModeNone = 2'b00;
  localparam logic [1:0] ModeLwl  = 2'b01;
  localparam logic [1:0] ModeLwr  = 2'b10;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  mode;
    logic [1:0]  lsb;
  } slot_t;

  slot_t            slot_q, slot_d;
  logic             rr_q, rr_d;  // 0: A wins the next tie, 1: M wins
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             contested;
  logic             grant_a, grant_m;
  logic             commit_en;
  logic             merge_commit;

  // --------------------------------------------------------------------------
  // Grant
  // --------------------------------------------------------------------------
  always_comb begin
    contested = a_valid & m_valid & ~hold;
    grant_a   = 1'b0;
    grant_m   = 1'b0;
    if (!hold) begin
      if (a_valid && m_valid) begin
        grant_a = ~rr_q;
        grant_m = rr_q;
      end else begin
        grant_a = a_valid;
        grant_m = m_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  // The slot empties every edge unless something is accepted.
  // Payload fields are left as-is when nothing is accepted; only valid qualifies them.
  always_comb begin
    slot_d       = slot_q;
    slot_d.valid = 1'b0;
    if (grant_a) begin
      slot_d.valid = 1'b1;
      slot_d.rd    = a_reg;
      slot_d.data  = a_data;
      slot_d.mode  = a_mode;
      slot_d.lsb   = 2'b00;
    end else if (grant_m) begin
      slot_d.valid = 1'b1;
      slot_d.rd    = m_reg;
      slot_d.data  = m_data;
      slot_d.mode  = m_mode;
      slot_d.lsb   = m_lsb;
    end
  end

  // After a contested grant the loser gets the next tie.
  always_comb begin
    rr_d = rr_q;
    if (contested) begin
      rr_d = grant_a;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (contested && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      rr_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Commit and read-port steal
  // --------------------------------------------------------------------------
  assign commit_en = slot_q.valid && (slot_q.rd != 5'd0) && (slot_q.mode != ModeNone);

  assign RegWrite         = commit_en ? slot_q.mode : ModeNone;
  assign WriteReg         = slot_q.rd;
  assign WriteData        = slot_q.data;
  assign data_address2LSB = slot_q.lsb;

  // Partial-word merges read the old value through port 2 in the same cycle.
  assign merge_commit = (RegWrite == ModeLwl) || (RegWrite == ModeLwr);
  assign ReadReg2     = merge_commit ? slot_q.rd : core_ReadReg2;
  assign port2_stolen = merge_commit;

  // Hazard view includes suppressed writes: the slot is still occupied.
  assign pend_valid     = slot_q.valid;
  assign pend_reg       = slot_q.rd;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned CNT_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, m_valid, hold;
  logic             a_ready, m_ready;
  logic [4:0]       a_reg, m_reg, core_ReadReg2;
  logic [31:0]      a_data, m_data;
  logic [1:0]       a_mode, m_mode, m_lsb;
  logic [1:0]       RegWrite, data_address2LSB;
  logic [4:0]       WriteReg, ReadReg2, pend_reg;
  logic [31:0]      WriteData;
  logic             port2_stolen, pend_valid;
  logic [CNT_W-1:0] conflict_count;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_reg            (a_reg),
    .a_data           (a_data),
    .a_mode           (a_mode),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_reg            (m_reg),
    .m_data           (m_data),
    .m_mode           (m_mode),
    .m_lsb            (m_lsb),
    .hold             (hold),
    .core_ReadReg2    (core_ReadReg2),
    .RegWrite         (RegWrite),
    .WriteReg         (WriteReg),
    .WriteData        (WriteData),
    .data_address2LSB (data_address2LSB),
    .ReadReg2         (ReadReg2),
    .port2_stolen     (port2_stolen),
    .pend_valid       (pend_valid),
    .pend_reg         (pend_reg),
    .conflict_count   (conflict_count)
  );

  // Register file the arbiter feeds (little-endian LWL/LWR merge semantics).
  logic [31:0] rf [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_reg = 5'd0;
  logic [31:0] pre_val = 32'd0;
  logic [31:0] rd2, merged;

  always_comb begin
    int sh;
    rd2    = rf[ReadReg2];
    merged = WriteData;
    if (RegWrite == 2'b01) begin
      sh     = 8 * (3 - int'(data_address2LSB));
      merged = (WriteData << sh) | (rd2 & ((32'h1 << sh) - 32'h1));
    end else if (RegWrite == 2'b10) begin
      sh     = 8 * int'(data_address2LSB);
      merged = (WriteData >> sh) | (rd2 & ~(32'hFFFF_FFFF >> sh));
    end
  end

  always @(posedge clk) begin
    if (pre_en) rf[pre_reg] <= pre_val;
    else if (RegWrite != 2'b00) rf[WriteReg] <= merged;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: the pending commit and whose turn it is on a tie.
  bit          s_valid;
  logic [4:0]  s_reg;
  logic [31:0] s_data;
  logic [1:0]  s_mode, s_lsb;
  bit          turn_m;
  int          conflicts;

  task automatic model_reset();
    s_valid = 0; s_reg = '0; s_data = '0; s_mode = '0; s_lsb = '0;
    turn_m = 0; conflicts = 0;
  endtask

  task automatic model_grants(output bit ga, output bit gm);
    ga = 0; gm = 0;
    if (!hold) begin
      if (a_valid && m_valid) begin
        ga = !turn_m; gm = turn_m;
      end else begin
        ga = a_valid; gm = m_valid;
      end
    end
  endtask

  task automatic model_step();
    bit ga, gm;
    if (!reset) begin
      model_reset();
      return;
    end
    model_grants(ga, gm);
    if (!hold && a_valid && m_valid) begin
      turn_m = ga;
      if (conflicts < MAXC) conflicts++;
    end
    if (ga) begin
      s_valid = 1; s_reg = a_reg; s_data = a_data; s_mode = a_mode; s_lsb = 2'b00;
    end else if (gm) begin
      s_valid = 1; s_reg = m_reg; s_data = m_data; s_mode = m_mode; s_lsb = m_lsb;
    end else begin
      s_valid = 0;
    end
  endtask

  task automatic model_check();
    bit ga, gm;
    logic [1:0] erw;
    bit steal;
    model_grants(ga, gm);
    erw   = (s_valid && s_reg != 5'd0 && s_mode != 2'b00) ? s_mode : 2'b00;
    steal = (erw == 2'b01) || (erw == 2'b10);
    check("a_ready",        32'(a_ready),          32'(ga));
    check("m_ready",        32'(m_ready),          32'(gm));
    check("RegWrite",       32'(RegWrite),         32'(erw));
    check("WriteReg",       32'(WriteReg),         32'(s_reg));
    check("WriteData",      WriteData,             s_data);
    check("lsb",            32'(data_address2LSB), 32'(s_lsb));
    check("ReadReg2",       32'(ReadReg2),         32'(steal ? s_reg : core_ReadReg2));
    check("port2_stolen",   32'(port2_stolen),     32'(steal));
    check("pend_valid",     32'(pend_valid),       32'(s_valid));
    check("pend_reg",       32'(pend_reg),         32'(s_reg));
    check("conflict_count", 32'(conflict_count),   32'(conflicts));
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances one edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    a_valid = 0; m_valid = 0; hold = 0;
    a_mode = 2'b00; m_mode = 2'b00;
  endtask

  task automatic preload(input logic [4:0] r, input logic [31:0] v);
    pre_en = 1'b1; pre_reg = r; pre_val = v;
    @(posedge clk);
    model_step();
    #1 pre_en = 1'b0;
  endtask

  typedef struct {
    bit         av, mv, hd;
    logic [4:0] ar;  logic [31:0] ad; logic [1:0] am;
    logic [4:0] mr;  logic [31:0] md; logic [1:0] mm; logic [1:0] ml;
    bit         e_ar, e_mr;
    logic [1:0] e_rw;
    logic [4:0] e_wr;
    bit         e_pv;
  } vec_t;

  vec_t vec [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected outputs in each row are those seen during that cycle (from the previous accept).
    vec[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 2'b11, 5'd0, 32'd0, 2'b00, 2'b00,
               1'b1, 1'b0, 2'b00, 5'd0, 1'b0};
    vec[1] = '{1'b1, 1'b1, 1'b0, 5'd1, 32'd1, 2'b11, 5'd2, 32'd2, 2'b11, 2'b00,
               1'b1, 1'b0, 2'b11, 5'd5, 1'b1};
    vec[2] = '{1'b1, 1'b1, 1'b0, 5'd3, 32'd3, 2'b11, 5'd4, 32'd4, 2'b11, 2'b00,
               1'b0, 1'b1, 2'b11, 5'd1, 1'b1};
    vec[3] = '{1'b1, 1'b1, 1'b0, 5'd3, 32'd3, 2'b11, 5'd4, 32'd4, 2'b11, 2'b00,
               1'b1, 1'b0, 2'b11, 5'd4, 1'b1};
    vec[4] = '{1'b1, 1'b1, 1'b0, 5'd3, 32'd3, 2'b11, 5'd4, 32'd4, 2'b11, 2'b00,
               1'b0, 1'b1, 2'b11, 5'd3, 1'b1};
    vec[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 2'b00, 2'b00,
               1'b0, 1'b0, 2'b11, 5'd4, 1'b1};
    vec[6] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 2'b00, 2'b00,
               1'b0, 1'b0, 2'b00, 5'd4, 1'b0};

    reset = 1'b0;
    idle();
    a_reg = '0; a_data = '0; m_reg = '0; m_data = '0; m_lsb = '0;
    core_ReadReg2 = 5'd7;
    model_reset();
    for (int i = 0; i < 32; i++) preload(5'(i), 32'd0);

    // Reset state; ready still follows the grant rules while in reset.
    a_valid = 1'b1;
    #2;
    check("rst_RegWrite",   32'(RegWrite), 32'd0);
    check("rst_WriteReg",   32'(WriteReg), 32'd0);
    check("rst_WriteData",  WriteData, 32'd0);
    check("rst_lsb",        32'(data_address2LSB), 32'd0);
    check("rst_pend_valid", 32'(pend_valid), 32'd0);
    check("rst_pend_reg",   32'(pend_reg), 32'd0);
    check("rst_ReadReg2",   32'(ReadReg2), 32'd7);
    check("rst_stolen",     32'(port2_stolen), 32'd0);
    check("rst_conflicts",  32'(conflict_count), 32'd0);
    check("rst_a_ready",    32'(a_ready), 32'd1);
    check("rst_m_ready",    32'(m_ready), 32'd0);
    a_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Table-driven sequence from reset.
    for (int i = 0; i < 7; i++) begin
      a_valid = vec[i].av; m_valid = vec[i].mv; hold = vec[i].hd;
      a_reg = vec[i].ar; a_data = vec[i].ad; a_mode = vec[i].am;
      m_reg = vec[i].mr; m_data = vec[i].md; m_mode = vec[i].mm; m_lsb = vec[i].ml;
      @(negedge clk);
      check($sformatf("vec%0d_a_ready", i),    32'(a_ready),    32'(vec[i].e_ar));
      check($sformatf("vec%0d_m_ready", i),    32'(m_ready),    32'(vec[i].e_mr));
      check($sformatf("vec%0d_RegWrite", i),   32'(RegWrite),   32'(vec[i].e_rw));
      check($sformatf("vec%0d_WriteReg", i),   32'(WriteReg),   32'(vec[i].e_wr));
      check($sformatf("vec%0d_pend_valid", i), 32'(pend_valid), 32'(vec[i].e_pv));
      @(posedge clk);
      model_step();
      #1;
    end
    check("tbl_conflicts", 32'(conflict_count), 32'd4);
    check("tbl_rf5", rf[5], 32'hDEADBEEF);
    check("tbl_rf4", rf[4], 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      m_valid = 1'($urandom_range(0, 1));
      hold    = ($urandom_range(0, 3) == 0);
      a_reg   = 5'($urandom_range(0, 31));
      m_reg   = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      m_data  = $urandom;
      a_mode  = 2'($urandom_range(0, 3));
      m_mode  = 2'($urandom_range(0, 3));
      m_lsb   = 2'($urandom_range(0, 3));
      core_ReadReg2 = 5'($urandom_range(0, 31));
      cycle();
    end

    // Hold for three cycles with both requesting; then the grant follows the tie pointer.
    begin
      bit t0;
      int c0;
      idle();
      cycle();
      t0 = turn_m;
      c0 = conflicts;
      a_valid = 1; m_valid = 1; a_reg = 5'd10; m_reg = 5'd11;
      a_mode = 2'b11; m_mode = 2'b11; a_data = 32'hA; m_data = 32'hB; hold = 1;
      for (int i = 0; i < 3; i++) begin
        #1;
        check("hold_a_ready", 32'(a_ready), 32'd0);
        check("hold_m_ready", 32'(m_ready), 32'd0);
        cycle();
        check("hold_pend_valid", 32'(pend_valid), 32'd0);
      end
      check("hold_conflicts", 32'(conflict_count), 32'(c0));
      hold = 0;
      #1;
      check("after_hold_a_ready", 32'(a_ready), 32'(!t0));
      check("after_hold_m_ready", 32'(m_ready), 32'(t0));
      cycle();
    end

    // LWL merge through the stolen read port.
    idle();
    core_ReadReg2 = 5'd3;
    cycle();
    preload(5'd8, 32'hAABBCCDD);
    m_valid = 1; m_reg = 5'd8; m_data = 32'h11223344; m_mode = 2'b01; m_lsb = 2'd1;
    cycle();
    idle();
    check("lwl_RegWrite", 32'(RegWrite), 32'd1);
    check("lwl_ReadReg2", 32'(ReadReg2), 32'd8);
    check("lwl_stolen",   32'(port2_stolen), 32'd1);
    cycle();
    check("lwl_rf8", rf[8], 32'h3344CCDD);
    check("lwl_ReadReg2_back", 32'(ReadReg2), 32'd3);

    // Write to $0 is accepted but suppressed.
    a_valid = 1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF; a_mode = 2'b11;
    #1 check("r0_a_ready", 32'(a_ready), 32'd1);
    cycle();
    idle();
    check("r0_pend_valid", 32'(pend_valid), 32'd1);
    check("r0_RegWrite",   32'(RegWrite), 32'd0);
    cycle();
    check("r0_rf0", rf[0], 32'd0);

    // Reset mid-commit drops the in-flight write immediately.
    preload(5'd9, 32'h0BADF00D);
    a_valid = 1; a_reg = 5'd9; a_data = 32'h12345678; a_mode = 2'b11;
    cycle();
    idle();
    check("mid_RegWrite_before", 32'(RegWrite), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("mid_RegWrite",   32'(RegWrite), 32'd0);
    check("mid_pend_valid", 32'(pend_valid), 32'd0);
    check("mid_WriteData",  WriteData, 32'd0);
    check("mid_conflicts",  32'(conflict_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    check("mid_rf9", rf[9], 32'h0BADF00D);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
